truth_table_eval: RTL

- Parametrised N-input Boolean truth-table evaluator, the successor to the fixed 3-input case-statement gate modules.
- The truth table is runtime-reprogrammable through a serial configuration port into a shadow register, then committed atomically.
- Input vectors are evaluated through a one-stage registered pipeline with valid/ready handshakes.
- Used as the generic logic-gate model in circuit-simulation benches, replacing one module per truth table.

---
 rtl/tt_pkg.sv | 11 +
 rtl/tt_cfg_loader.sv | 53 +++++
 rtl/truth_table_eval.sv | 57 +++++
 3 files changed

// File: rtl/tt_pkg.sv
// tt_pkg: shared config state, default table and MSB-first table lookup
package tt_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} cfg_state_e;
    localparam logic [7:0] DEFAULT_TT_3IN = 8'h84;
    // bit `last` holds row 0, so row r lives at bit last-r
    function automatic logic tt_lookup(input logic [255:0] tbl, input logic [7:0] last, input logic [7:0] row);
        logic [7:0] idx;
        idx = last - row;
        return tbl[idx];
    endfunction
endpackage

// File: rtl/tt_cfg_loader.sv
// tt_cfg_loader: serial truth-table loader with shadow register and one-cycle commit
module tt_cfg_loader import tt_pkg::*; #(
    parameter int TT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            commit,
    output logic [TT_W-1:0] shadow
);
    localparam int CW = $clog2(TT_W);
    cfg_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TT_W-1:0] shadow_q, shadow_d;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: if (cfg_start) begin
                state_d  = LOAD;
                cnt_d    = '0;
                shadow_d = '0;
            end
            LOAD: if (cfg_start) begin
                cnt_d    = '0;
                shadow_d = '0;
            end else if (cfg_valid) begin
                shadow_d = {shadow_q[TT_W-2:0], cfg_bit};
                cnt_d    = cnt_q + CW'(1);
                state_d  = (cnt_q == CW'(TT_W-1)) ? COMMIT : LOAD;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end
    assign cfg_busy = state_q != IDLE;
    assign commit   = state_q == COMMIT;
    assign shadow   = shadow_q;
endmodule

// File: rtl/truth_table_eval.sv
// truth_table_eval: reprogrammable N-input truth-table evaluator with registered valid/ready output
module truth_table_eval import tt_pkg::*; #(
    parameter int              N_IN    = 3,
    parameter int              TT_W    = 2**N_IN,
    parameter logic [TT_W-1:0] INIT_TT = TT_W'(DEFAULT_TT_3IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic [TT_W-1:0] tt_active
);
    logic [TT_W-1:0] tt_active_q, tt_active_d, shadow;
    logic out_valid_q, out_valid_d, out_bit_q, out_bit_d, commit, xfer;
    tt_cfg_loader #(.TT_W(TT_W)) u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .commit    (commit),
        .shadow    (shadow)
    );
    assign in_ready = !out_valid_q || out_ready;
    assign xfer     = in_valid && in_ready;
    // the table swaps on the commit edge, so a vector taken that same edge still sees the old table
    always_comb begin
        tt_active_d = commit ? shadow : tt_active_q;
        out_valid_d = xfer || (out_valid_q && !out_ready);
        out_bit_d   = xfer ? tt_lookup(256'(tt_active_q), 8'(TT_W-1), 8'(in_data)) : out_bit_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_active_q <= INIT_TT;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
        end else begin
            tt_active_q <= tt_active_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
        end
    end
    assign cfg_done  = commit;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign tt_active = tt_active_q;
endmodule
